imem_responder: RTL and testbench



---
 rtl/imem_pkg.sv | 26 ++
 rtl/imem_lat_ctr.sv | 41 ++++
 rtl/imem_responder.sv | 130 +++++++++++++
 tb/tb_imem_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the multi-cycle instruction/data memory responder.
package imem_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned LAT_MIN = 1;
    localparam int unsigned LAT_MAX = 15;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    // Request payload captured at acceptance and held for the whole access.
    typedef struct packed {
        op_e               op;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/imem_lat_ctr.sv
// Loadable 4-bit latency down-counter; zero flag is kept as its own flop.
module imem_lat_ctr
    import imem_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zero_q, zero_d;

    // Load wins over decrement; decrement saturates at zero.
    always_comb begin
        cnt_d  = cnt_q;
        zero_d = zero_q;
        if (load_i) begin
            cnt_d  = load_val_i;
            zero_d = (load_val_i == '0);
        end else if (dec_i && !zero_q) begin
            cnt_d  = cnt_q - CNT_W'(1);
            zero_d = (cnt_q == CNT_W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= zero_d;
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/imem_responder.sv
// Byte-addressed, big-endian 16-bit memory that completes each accepted read
// or write a fixed LATENCY cycles after acceptance, with stall/done/err status.
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              done,
    output logic              stall,
    output logic              err
);

    localparam int unsigned MEM_BYTES = 2 ** ADDR_W;

    generate
        if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
            $error("imem_responder: LATENCY must be within 1..15");
        end
    endgenerate

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    req_t              req_q, req_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              ctr_load_c;
    logic              ctr_dec_c;
    logic              ctr_zero;
    logic              mem_we_c;
    logic              req_ok_c;
    logic [ADDR_W-1:0] addr_hi_c;
    logic [DATA_W-1:0] rdata_c;

    logic [BYTE_W-1:0] mem_q [MEM_BYTES];

    imem_lat_ctr u_lat_ctr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ctr_load_c),
        .load_val_i (CNT_W'(LATENCY - 1)),
        .dec_i      (ctr_dec_c),
        .zero_o     (ctr_zero)
    );

    // Low byte address wraps around the top of memory.
    assign addr_hi_c = addr_q + ADDR_W'(1);
    assign rdata_c   = {mem_q[addr_q], mem_q[addr_hi_c]};
    assign req_ok_c  = (rd ^ wr) && !addr[0];

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        req_d      = req_q;
        data_out_d = data_out_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        ctr_load_c = 1'b0;
        ctr_dec_c  = 1'b0;
        mem_we_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_ok_c) begin
                    addr_d     = addr;
                    req_d.op   = wr ? OP_WR : OP_RD;
                    req_d.wdata = data_in;
                    ctr_load_c = 1'b1;
                    state_d    = BUSY;
                end else if (rd || wr) begin
                    err_d = 1'b1;
                end
            end
            BUSY: begin
                if (!ctr_zero) begin
                    ctr_dec_c = 1'b1;
                end else begin
                    if (req_q.op == OP_WR) begin
                        mem_we_c = 1'b1;
                    end else begin
                        data_out_d = rdata_c;
                    end
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            req_q      <= '{op: OP_RD, wdata: '0};
            data_out_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[addr_q]    <= req_q.wdata[DATA_W-1:BYTE_W];
            mem_q[addr_hi_c] <= req_q.wdata[BYTE_W-1:0];
        end
    end

    assign data_out = data_out_q;
    assign done     = done_q;
    assign err      = err_q;
    assign stall    = (state_q == BUSY);

endmodule

// File: tb/tb_imem_responder.sv
// Randomized and directed bench for imem_responder with a transaction-level memory model.
module tb_imem_responder;

    localparam int unsigned LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd = 1'b0, wr = 1'b0;
    logic [15:0] addr = '0, data_in = '0;
    logic [15:0] data_out;
    logic        done, stall, err;

    logic        rd1 = 1'b0, wr1 = 1'b0;
    logic [15:0] addr1 = '0, din1 = '0;
    logic [15:0] dout1;
    logic        done1, stall1, err1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    imem_responder #(.ADDR_W(16), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst), .rd(rd), .wr(wr), .addr(addr), .data_in(data_in),
        .data_out(data_out), .done(done), .stall(stall), .err(err)
    );

    imem_responder #(.ADDR_W(16), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .rd(rd1), .wr(wr1), .addr(addr1), .data_in(din1),
        .data_out(dout1), .done(done1), .stall(stall1), .err(err1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: an access accepted at edge k completes at edge k+LAT.
    logic [7:0]  ref_mem [int];
    bit          pending = 0;
    longint      edge_no = 0;
    longint      finish_edge = 0;
    bit          p_wr = 0;
    logic [15:0] p_addr = '0, p_data = '0;
    bit          exp_stall = 0, exp_done = 0, exp_err = 0, exp_known = 1;
    logic [15:0] exp_dout = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   = 0;
            exp_stall = 0;
            exp_done  = 0;
            exp_err   = 0;
            exp_dout  = '0;
            exp_known = 1;
        end else begin
            int lo_idx;
            edge_no++;
            exp_done = 0;
            exp_err  = 0;
            lo_idx   = (int'(p_addr) + 1) % 65536;
            if (pending) begin
                if (edge_no == finish_edge) begin
                    pending  = 0;
                    exp_done = 1;
                    if (p_wr) begin
                        ref_mem[int'(p_addr)] = p_data[15:8];
                        ref_mem[lo_idx]       = p_data[7:0];
                    end else if (ref_mem.exists(int'(p_addr)) && ref_mem.exists(lo_idx)) begin
                        exp_dout  = {ref_mem[int'(p_addr)], ref_mem[lo_idx]};
                        exp_known = 1;
                    end else begin
                        exp_known = 0;
                    end
                end
            end else if (rd || wr) begin
                if ((rd && wr) || addr[0]) begin
                    exp_err = 1;
                end else begin
                    pending     = 1;
                    finish_edge = edge_no + longint'(LAT);
                    p_wr        = wr;
                    p_addr      = addr;
                    p_data      = data_in;
                end
            end
            exp_stall = pending;
        end
    end

    // Every-cycle comparison of the main instance against the model.
    always @(negedge clk) begin
        chk("stall", 32'(stall), 32'(exp_stall));
        chk("done", 32'(done), 32'(exp_done));
        chk("err", 32'(err), 32'(exp_err));
        if (exp_known) chk("data_out", 32'(data_out), 32'(exp_dout));
    end

    task automatic idle(input int n);
        rd = 1'b0;
        wr = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Issue at a negedge; hold until done/err. Inputs stay asserted on done so a
    // follow-up request can be presented back-to-back.
    task automatic xact(input bit r, input bit w, input logic [15:0] a, input logic [15:0] d,
                        input bit scr, input logic [15:0] scr_a, input logic [15:0] scr_d,
                        output logic [15:0] q, output int stall_cyc, output bit got_err);
        rd = r; wr = w; addr = a; data_in = d;
        stall_cyc = 0;
        got_err   = 0;
        q         = data_out;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stall) stall_cyc++;
            if (done) begin
                q = data_out;
                return;
            end
            if (err) begin
                got_err = 1;
                rd = 1'b0;
                wr = 1'b0;
                return;
            end
            if (scr && i == 0 && stall) begin
                addr    = scr_a;
                data_in = scr_d;
            end
        end
        chk("xact_timeout", 32'd1, 32'd0);
        rd = 1'b0;
        wr = 1'b0;
    endtask

    task automatic wait_done1(input string nm);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done1) return;
        end
        chk(nm, 32'd1, 32'd0);
    endtask

    initial begin
        logic [15:0] q;
        logic [15:0] w0;
        int          sc;
        bit          ge;

        // Reset asserted mid-cycle, then a quiet idle stretch.
        #3 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(10);
        chk("idle_data_out", 32'(data_out), 32'h0);
        chk("idle_stall", 32'(stall), 32'h0);
        chk("idle_done", 32'(done), 32'h0);
        chk("idle_err", 32'(err), 32'h0);

        // Minimum latency: preload then back-to-back reads.
        wr1 = 1'b1; addr1 = 16'h0000; din1 = 16'h1111;
        wait_done1("l1_wr0_timeout");
        addr1 = 16'h0002; din1 = 16'h2222;
        wait_done1("l1_wr2_timeout");
        wr1 = 1'b0; rd1 = 1'b1; addr1 = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("l1_stall", 32'(stall1), 32'((i % 2) == 0));
            chk("l1_done", 32'(done1), 32'((i % 2) == 1));
            chk("l1_err", 32'(err1), 32'h0);
            if (i == 1) begin
                chk("l1_rdata0", 32'(dout1), 32'h1111);
                addr1 = 16'h0002;
            end
            if (i == 3) begin
                chk("l1_rdata2", 32'(dout1), 32'h2222);
                rd1 = 1'b0;
            end
        end

        // Write then read back.
        xact(0, 1, 16'h0010, 16'hA5C3, 0, '0, '0, q, sc, ge);
        chk("wr_stall_cycles", 32'(sc), 32'd4);
        chk("wr_data_out_held", 32'(q), 32'h0000);
        xact(1, 0, 16'h0010, 16'h0000, 0, '0, '0, q, sc, ge);
        chk("rd_stall_cycles", 32'(sc), 32'd4);
        chk("rd_data", 32'(q), 32'hA5C3);
        idle(2);

        // Initialise a pool of words so every random read is predictable.
        for (int i = 0; i < 32; i++) begin
            xact(0, 1, 16'(i * 2), 16'($urandom), 0, '0, '0, q, sc, ge);
        end
        xact(0, 1, 16'hFFFE, 16'($urandom), 0, '0, '0, q, sc, ge);
        xact(0, 1, 16'h0004, 16'h4444, 0, '0, '0, q, sc, ge);
        xact(0, 1, 16'h0020, 16'h1234, 0, '0, '0, q, sc, ge);
        xact(0, 1, 16'h0000, 16'h0BAD, 0, '0, '0, q, sc, ge);
        idle(1);

        // Rejected requests.
        xact(1, 0, 16'h0003, 16'h0000, 0, '0, '0, q, sc, ge);
        chk("err_odd", 32'(ge), 32'd1);
        idle(2);
        xact(1, 1, 16'h0004, 16'hDEAD, 0, '0, '0, q, sc, ge);
        chk("err_both", 32'(ge), 32'd1);
        idle(1);
        xact(1, 0, 16'h0004, 16'h0000, 0, '0, '0, q, sc, ge);
        chk("err_mem_unchanged", 32'(q), 32'h4444);
        idle(1);

        // Reset two cycles into a write aborts it.
        wr = 1'b1; addr = 16'h0020; data_in = 16'hBEEF;
        @(negedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_data_out", 32'(data_out), 32'h0);
        @(negedge clk);
        wr = 1'b0;
        rst = 1'b0;
        idle(1);
        xact(1, 0, 16'h0020, 16'h0000, 0, '0, '0, q, sc, ge);
        chk("rst_write_aborted", 32'(q), 32'h1234);
        idle(1);

        // Top-word wrap while busy inputs are scrambled.
        xact(0, 1, 16'hFFFE, 16'h55AA, 1, 16'h0000, 16'hFFFF, q, sc, ge);
        idle(1);
        xact(1, 0, 16'hFFFE, 16'h0000, 0, '0, '0, q, sc, ge);
        chk("wrap_data", 32'(q), 32'h55AA);
        xact(1, 0, 16'h0000, 16'h0000, 0, '0, '0, q, sc, ge);
        chk("wrap_low_unchanged", 32'(q), 32'h0BAD);
        idle(1);

        // Randomized traffic, model-checked every cycle.
        for (int t = 0; t < 300; t++) begin
            int          kind;
            int          idx;
            int          gap;
            logic [15:0] a;
            kind = int'($urandom_range(0, 9));
            idx  = int'($urandom_range(0, 32));
            a    = (idx == 32) ? 16'hFFFE : 16'(idx * 2);
            w0   = 16'($urandom);
            if (kind == 0)      xact(1, 1, a, w0, 0, '0, '0, q, sc, ge);
            else if (kind == 1) xact(1, 0, a | 16'h0001, w0, 0, '0, '0, q, sc, ge);
            else if (kind <= 5) xact(0, 1, a, w0, ($urandom_range(0, 3) == 0), 16'($urandom), 16'($urandom), q, sc, ge);
            else                xact(1, 0, a, w0, ($urandom_range(0, 3) == 0), 16'($urandom), 16'($urandom), q, sc, ge);
            gap = int'($urandom_range(0, 2));
            if (gap > 0) idle(gap);
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
